// File: rtl/ifetch_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue_pkg
// Description : Shared types and default sizing for the instruction fetch
//               queue: fetch FSM state encoding and default WIDTH/DEPTH.
// Revision    : 1.0 - initial release
// ============================================================================
package ifetch_queue_pkg;

    // Default sizing used by the queue and its buffer
    localparam int c_DEFAULT_WIDTH = 16;
    localparam int c_DEFAULT_DEPTH = 2;

    // Fetch sequencer states (explicit 2-bit encoding)
    typedef enum logic [1:0] {
        IDLE     = 2'd0,   // no request outstanding, may issue
        WAIT_ACK = 2'd1,   // request outstanding, response will be kept
        DROP     = 2'd2    // request outstanding, response will be discarded
    } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/ifetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_fifo
// Description : Small power-of-2 FIFO holding fetched {pc, instruction}
//               entries. Flush has priority over push and pop. The head
//               entry is read straight from storage registers.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_fifo
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = c_DEFAULT_DEPTH,
    parameter int WIDTH = 2 * c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic [DEPTH:0]   count,
    output logic             full,
    output logic             empty
);

    localparam int             c_PTR_W    = $clog2(DEPTH);
    localparam logic [DEPTH:0] c_FULL_CNT = (DEPTH+1)'(DEPTH);
    localparam logic [DEPTH:0] c_CNT_ONE  = (DEPTH+1)'(1);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [DEPTH:0]     r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign empty     = (r_count == '0);
    assign full      = (r_count == c_FULL_CNT);
    assign w_do_pop  = pop & ~empty;
    // A push into a full buffer is only legal when the head leaves the same cycle
    assign w_do_push = push & (~full | w_do_pop);
    assign head_data = r_mem[r_rd_ptr];
    assign count     = r_count;

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage; cleared on reset so the head reads zero out of reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_do_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifetch_queue
// Description : Instruction fetch sequencer with prefetch buffer. Issues one
//               memory read at a time from pc_in while the buffer has room,
//               pushes {address, data} on acknowledge, and discards
//               responses belonging to a flushed fetch stream.
// Revision    : 1.0 - initial release
// ============================================================================
module ifetch_queue
    import ifetch_queue_pkg::*;
#(
    parameter int DEPTH = c_DEFAULT_DEPTH,
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pc_in,
    output logic             pc_step,
    input  logic             flush,
    output logic             mem_req,
    output logic [WIDTH-1:0] mem_addr,
    input  logic             mem_ack,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic [WIDTH-1:0] instr_data,
    output logic [WIDTH-1:0] instr_pc
);

    fetch_state_t       r_state;
    fetch_state_t       w_state_nxt;
    logic               r_mem_req;
    logic               w_mem_req_nxt;
    logic [WIDTH-1:0]   r_mem_addr;
    logic [WIDTH-1:0]   w_mem_addr_nxt;

    logic               w_push;
    logic               w_pop;
    logic [2*WIDTH-1:0] w_head;
    logic [DEPTH:0]     w_count;
    logic               w_full;
    logic               w_empty;

    // State and the registered memory request; request is held until acked
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_mem_req  <= w_mem_req_nxt;
            r_mem_addr <= w_mem_addr_nxt;
        end
    end

    // Next-state: issue from IDLE when there is room, retire on ack, and
    // remember a flush that arrives while a request is still in flight
    always_comb begin
        w_state_nxt    = r_state;
        w_mem_req_nxt  = r_mem_req;
        w_mem_addr_nxt = r_mem_addr;
        case (r_state)
            IDLE: begin
                // Any ack seen here is stale and is ignored
                if (!flush && !w_full) begin
                    w_state_nxt    = WAIT_ACK;
                    w_mem_req_nxt  = 1'b1;
                    w_mem_addr_nxt = pc_in;
                end
            end
            WAIT_ACK: begin
                if (mem_ack) begin
                    w_state_nxt   = IDLE;
                    w_mem_req_nxt = 1'b0;
                end else if (flush) begin
                    w_state_nxt   = DROP;
                end
            end
            DROP: begin
                if (mem_ack) begin
                    w_state_nxt   = IDLE;
                    w_mem_req_nxt = 1'b0;
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_mem_req_nxt = 1'b0;
            end
        endcase
    end

    // Outputs: keep a response only when it answers a live, unflushed request
    always_comb begin
        w_push = 1'b0;
        if ((r_state == WAIT_ACK) && mem_ack && !flush) begin
            w_push = 1'b1;
        end
    end

    assign w_pop       = instr_ready & ~w_empty;
    assign pc_step     = w_push;
    assign mem_req     = r_mem_req;
    assign mem_addr    = r_mem_addr;
    assign instr_valid = (w_count != '0);
    assign instr_pc    = w_head[2*WIDTH-1:WIDTH];
    assign instr_data  = w_head[WIDTH-1:0];

    ifetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (2*WIDTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_push),
        .push_data ({r_mem_addr, mem_rdata}),
        .pop       (w_pop),
        .flush     (flush),
        .head_data (w_head),
        .count     (w_count),
        .full      (w_full),
        .empty     (w_empty)
    );

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifetch_queue
// Description : Self-checking bench for ifetch_queue. Directed scenarios plus
//               randomized traffic compared each cycle against a
//               transaction-level model (queue of fetched entries and a
//               single outstanding-request record).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifetch_queue;

    localparam int DEPTH = 2;
    localparam int WIDTH = 16;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] pc_in;
    logic             pc_step;
    logic             flush;
    logic             mem_req;
    logic [WIDTH-1:0] mem_addr;
    logic             mem_ack;
    logic [WIDTH-1:0] mem_rdata;
    logic             instr_valid;
    logic             instr_ready;
    logic [WIDTH-1:0] instr_data;
    logic [WIDTH-1:0] instr_pc;

    ifetch_queue #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_in       (pc_in),
        .pc_step     (pc_step),
        .flush       (flush),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .instr_pc    (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [2*WIDTH-1:0] m_q[$];       // buffered {pc, data}, head at index 0
    bit                 m_pend;       // a request is outstanding
    bit                 m_dead;       // outstanding request belongs to a flushed stream
    logic [WIDTH-1:0]   m_addr;       // address of the outstanding request
    logic [WIDTH-1:0]   m_pc;         // program counter driven on pc_in
    logic [WIDTH-1:0]   m_flush_pc;   // PC loaded when a flush occurs

    int n_cmp;
    int n_err;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Model reaction to one clock edge with the given inputs
    task automatic model_edge(input logic f, input logic a, input logic [WIDTH-1:0] d,
                              input logic r, input logic [WIDTH-1:0] pc_now);
        bit step_now;
        int old_n;
        bit issue;
        step_now = m_pend && !m_dead && a && !f;
        old_n    = m_q.size();
        issue    = !m_pend && !f && (old_n < DEPTH);
        if (f) begin
            m_q.delete();
        end else begin
            if (r && old_n > 0) void'(m_q.pop_front());
            if (step_now) m_q.push_back({m_addr, d});
        end
        if (m_pend) begin
            if (a) m_pend = 0;
            else if (f) m_dead = 1;
        end else if (issue) begin
            m_pend = 1;
            m_dead = 0;
            m_addr = pc_now;
        end
        if (f) m_pc = m_flush_pc;
        else if (step_now) m_pc = m_pc + 16'd1;
    endtask

    // Compare every observable output against the model
    task automatic compare_outputs(input logic f, input logic a);
        check("mem_req", 32'(mem_req), 32'(m_pend));
        if (m_pend) check("mem_addr", 32'(mem_addr), 32'(m_addr));
        check("pc_step", 32'(pc_step), 32'(m_pend && !m_dead && a && !f));
        check("instr_valid", 32'(instr_valid), 32'(m_q.size() != 0));
        if (m_q.size() != 0) begin
            check("instr_pc", 32'(instr_pc), 32'(m_q[0][2*WIDTH-1:WIDTH]));
            check("instr_data", 32'(instr_data), 32'(m_q[0][WIDTH-1:0]));
        end
    endtask

    // One clock cycle: entered at posedge+1, returns at next posedge+1
    task automatic drive_cycle(input logic f, input logic a, input logic [WIDTH-1:0] d,
                               input logic r);
        logic [WIDTH-1:0] pc_now;
        pc_now      = m_pc;
        pc_in       = pc_now;
        flush       = f;
        mem_ack     = a;
        mem_rdata   = d;
        instr_ready = r;
        #4;
        compare_outputs(f, a);
        @(posedge clk);
        model_edge(f, a, d, r, pc_now);
        #1;
    endtask

    // Asynchronous reset pulse mid-cycle with a stale ack held high
    task automatic async_reset();
        logic [WIDTH-1:0] pc_now;
        pc_now      = m_pc;
        pc_in       = pc_now;
        flush       = 1'b0;
        mem_ack     = 1'b1;
        mem_rdata   = 16'hDEAD;
        instr_ready = 1'b1;
        #1;
        rst = 1'b1;
        #1;
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_pc_step", 32'(pc_step), 32'd0);
        check("rst_instr_valid", 32'(instr_valid), 32'd0);
        check("rst_instr_data", 32'(instr_data), 32'd0);
        check("rst_instr_pc", 32'(instr_pc), 32'd0);
        rst = 1'b0;
        m_q.delete();
        m_pend = 0;
        m_dead = 0;
        #2;
        compare_outputs(1'b0, 1'b1);
        @(posedge clk);
        model_edge(1'b0, 1'b1, 16'hDEAD, 1'b1, pc_now);
        #1;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        m_pend      = 0;
        m_dead      = 0;
        m_addr      = '0;
        m_pc        = 16'h0010;
        m_flush_pc  = 16'h0000;
        rst         = 1'b1;
        pc_in       = '0;
        flush       = 1'b0;
        mem_ack     = 1'b0;
        mem_rdata   = '0;
        instr_ready = 1'b0;
        @(posedge clk);
        #1;
        check("reset_mem_req", 32'(mem_req), 32'd0);
        check("reset_pc_step", 32'(pc_step), 32'd0);
        check("reset_instr_valid", 32'(instr_valid), 32'd0);
        rst = 1'b0;

        // Single fetch with one-cycle ack latency
        drive_cycle(1'b0, 1'b0, 16'h0000, 1'b0);
        check("basic_mem_addr", 32'(mem_addr), 32'h0010);
        drive_cycle(1'b0, 1'b1, 16'hA5A5, 1'b0);
        check("basic_valid", 32'(instr_valid), 32'd1);
        check("basic_data", 32'(instr_data), 32'hA5A5);
        check("basic_pc", 32'(instr_pc), 32'h0010);

        // Fill the buffer with zero-latency acks and no consumer
        m_pc = 16'h0000;
        async_reset();
        for (int i = 0; i < 8; i++) drive_cycle(1'b0, 1'b1, 16'($urandom), 1'b0);
        check("full_no_req", 32'(mem_req), 32'd0);
        check("full_valid", 32'(instr_valid), 32'd1);
        drive_cycle(1'b0, 1'b1, 16'h1111, 1'b1);
        drive_cycle(1'b0, 1'b0, 16'h0000, 1'b0);
        check("refill_req", 32'(mem_req), 32'd1);
        check("refill_addr", 32'(mem_addr), 32'h0002);

        // Slow memory: request held for five wait cycles, then one push
        for (int i = 0; i < 5; i++) drive_cycle(1'b0, 1'b0, 16'($urandom), 1'b0);
        check("slow_req_held", 32'(mem_req), 32'd1);
        check("slow_addr_held", 32'(mem_addr), 32'h0002);
        drive_cycle(1'b0, 1'b1, 16'h5A5A, 1'b0);
        check("slow_req_drop", 32'(mem_req), 32'd0);

        // Flush two cycles into a wait with one entry buffered
        m_pc = 16'h0100;
        async_reset();
        drive_cycle(1'b0, 1'b1, 16'h0BAD, 1'b0);
        drive_cycle(1'b0, 1'b0, 16'h0000, 1'b0);
        drive_cycle(1'b0, 1'b0, 16'h0000, 1'b0);
        m_flush_pc = 16'h0200;
        drive_cycle(1'b1, 1'b0, 16'h0000, 1'b0);
        check("drop_valid", 32'(instr_valid), 32'd0);
        check("drop_req_held", 32'(mem_req), 32'd1);
        drive_cycle(1'b0, 1'b1, 16'hFFFF, 1'b0);
        check("drop_no_push", 32'(instr_valid), 32'd0);
        drive_cycle(1'b0, 1'b0, 16'h0000, 1'b0);
        check("drop_new_addr", 32'(mem_addr), 32'h0200);

        // Flush coincident with ack and ready
        drive_cycle(1'b0, 1'b1, 16'h1234, 1'b0);
        drive_cycle(1'b0, 1'b0, 16'h0000, 1'b0);
        m_flush_pc = 16'h0300;
        drive_cycle(1'b1, 1'b1, 16'h4321, 1'b1);
        check("flack_valid", 32'(instr_valid), 32'd0);
        check("flack_req", 32'(mem_req), 32'd0);
        drive_cycle(1'b0, 1'b0, 16'h0000, 1'b0);
        check("flack_next_addr", 32'(mem_addr), 32'h0300);

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset();
            end else begin
                m_flush_pc = 16'($urandom);
                drive_cycle($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
                            16'($urandom), 1'($urandom_range(0, 1)));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: got no completion expected completion before 1000000");
        $fatal(1);
    end

endmodule
`default_nettype wire
